// File: rtl/bram_logger_pkg.sv
// rtl/bram_logger_pkg.sv - field layout and FSM state shared by the BRAM logger and reader
package bram_logger_pkg;

   localparam int TIMESTAMP_BITW = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } rd_state_e;

   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

   // Entries are padded to whole 32-bit words.
   function automatic int entry_bitw(input int data_bitw);
      return ceil_div(TIMESTAMP_BITW + data_bitw, 32) * 32;
   endfunction

   function automatic int addr_offset_bitw(input int data_bitw);
      return $clog2(entry_bitw(data_bitw) / 8);
   endfunction

endpackage

// File: rtl/bram_log_rd_buf.sv
// rtl/bram_log_rd_buf.sv - two-entry log entry FIFO driving the valid/ready stream side
module bram_log_rd_buf
   import bram_logger_pkg::*;
#(
   parameter int DATA_BITW    = 32,
   parameter bit STOP_ON_ZERO = 1'b1
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_flush,
   input  logic                      i_push,
   input  logic [TIMESTAMP_BITW-1:0] i_push_ts,
   input  logic [DATA_BITW-1:0]      i_push_data,
   input  logic                      i_push_last,
   input  logic                      i_resolve,
   input  logic                      i_resolve_zero,
   input  logic                      i_ready,
   output logic                      o_valid,
   output logic                      o_last,
   output logic                      o_pop,
   output logic [TIMESTAMP_BITW-1:0] o_ts,
   output logic [DATA_BITW-1:0]      o_data,
   output logic [1:0]                o_occ
);

   logic [1:0][TIMESTAMP_BITW-1:0] r_ts;
   logic [1:0][DATA_BITW-1:0]      r_data;
   logic [1:0]                     r_last;
   logic [1:0]                     r_occ;
   logic                           r_rd_ptr;
   logic                           w_wr_ptr;
   logic                           w_tail_ptr;
   logic                           w_head_ok;
   logic                           w_tail_zero;

   assign w_wr_ptr    = r_rd_ptr ^ r_occ[0];
   assign w_tail_ptr  = r_rd_ptr ^ r_occ[1];
   assign w_tail_zero = i_resolve && i_resolve_zero;

   // With zero-stop enabled the head may only leave once the entry behind it is known,
   // because a zero successor turns the head into the final beat.
   assign w_head_ok = (r_occ != 2'd0) &&
                      (!STOP_ON_ZERO || r_last[r_rd_ptr] || (r_occ == 2'd2) || i_resolve);

   assign o_valid = w_head_ok;
   assign o_last  = r_last[r_rd_ptr] || ((r_occ == 2'd1) && w_tail_zero);
   assign o_pop   = w_head_ok && i_ready;
   assign o_ts    = r_ts[r_rd_ptr];
   assign o_data  = r_data[r_rd_ptr];
   assign o_occ   = r_occ;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ts     <= '0;
         r_data   <= '0;
         r_last   <= '0;
         r_occ    <= 2'd0;
         r_rd_ptr <= 1'b0;
      end else if (i_flush) begin
         r_occ    <= 2'd0;
         r_rd_ptr <= 1'b0;
         r_last   <= '0;
      end else begin
         if (i_push) begin
            r_ts[w_wr_ptr]   <= i_push_ts;
            r_data[w_wr_ptr] <= i_push_data;
            r_last[w_wr_ptr] <= i_push_last;
         end
         if (w_tail_zero && (r_occ != 2'd0)) begin
            r_last[w_tail_ptr] <= 1'b1;
         end
         if (o_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_occ <= r_occ + {1'b0, i_push} - {1'b0, o_pop};
      end
   end

endmodule

// File: rtl/bram_log_reader.sv
// rtl/bram_log_reader.sv - drains timestamped log entries from BRAM into a valid/ready stream
module bram_log_reader
   import bram_logger_pkg::*;
#(
   parameter int LOG_DATA_BITW   = 32,
   parameter int NUM_LOG_ENTRIES = 16384,
   parameter bit STOP_ON_ZERO    = 1'b1,
   parameter int ENTRY_BITW      = entry_bitw(LOG_DATA_BITW),
   parameter int CNT_BITW        = $clog2(NUM_LOG_ENTRIES),
   parameter int ADDR_BITW       = CNT_BITW + addr_offset_bitw(LOG_DATA_BITW)
) (
   input  logic                      Clk_CI,
   input  logic                      Rst_RBI,
   input  logic                      Start_SI,
   input  logic                      Abort_SI,
   input  logic [CNT_BITW:0]         NumEntries_DI,
   output logic                      Busy_SO,
   output logic                      Done_SO,
   output logic [CNT_BITW:0]         NumRead_DO,
   output logic [TIMESTAMP_BITW-1:0] Timestamp_DO,
   output logic [LOG_DATA_BITW-1:0]  LogData_DO,
   output logic                      Valid_SO,
   input  logic                      Ready_SI,
   output logic                      Last_SO,
   output logic                      Bram_Clk_CO,
   output logic                      Bram_Rst_RO,
   output logic [ADDR_BITW-1:0]      Bram_Addr_DO,
   output logic                      Bram_En_SO,
   output logic [ENTRY_BITW/8-1:0]   Bram_WrEn_SO,
   output logic [ENTRY_BITW-1:0]     Bram_Wr_DO,
   input  logic [ENTRY_BITW-1:0]     Bram_Rd_DI
);

   localparam int                OFS_BITW = ADDR_BITW - CNT_BITW;
   localparam logic [CNT_BITW:0] FULL_CNT = (CNT_BITW + 1)'(NUM_LOG_ENTRIES);

   rd_state_e         r_state;
   rd_state_e         w_state_nxt;
   logic [CNT_BITW:0] r_target;
   logic [CNT_BITW:0] r_rd_idx;
   logic [CNT_BITW:0] r_num_read;
   logic              r_inflight;
   logic              r_inflight_last;

   logic [1:0]        w_occ;
   logic              w_pop;
   logic              w_rsp_zero;
   logic              w_zero_hit;
   logic              w_push;
   logic              w_room;
   logic              w_issue;
   logic              w_issue_last;
   logic              w_drained;
   logic              w_accept_start;

   assign w_rsp_zero     = STOP_ON_ZERO && (Bram_Rd_DI == '0);
   assign w_zero_hit     = r_inflight && w_rsp_zero;
   assign w_push         = r_inflight && !w_rsp_zero && !Abort_SI;
   assign w_drained      = (w_occ == 2'd0) && !r_inflight;
   assign w_accept_start = (r_state == IDLE) && Start_SI && !Abort_SI;

   // Counting this cycle's pop keeps one read issued per cycle while the stream drains.
   assign w_room       = ({1'b0, w_occ} + {2'b0, r_inflight}) < (3'd2 + {2'b0, w_pop});
   assign w_issue_last = (r_rd_idx == r_target - 1'b1);
   assign w_issue      = (r_state == READ) && (r_rd_idx < r_target) && w_room &&
                         !w_zero_hit && !Abort_SI;

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (Abort_SI) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (Start_SI) w_state_nxt = READ;
            READ:    if (w_zero_hit || (w_issue && w_issue_last)) w_state_nxt = DRAIN;
            DRAIN:   if (w_drained) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      Busy_SO      = (r_state != IDLE);
      Done_SO      = (r_state == DRAIN) && w_drained && !Abort_SI;
      Bram_En_SO   = w_issue;
      Bram_Addr_DO = {r_rd_idx[CNT_BITW-1:0], {OFS_BITW{1'b0}}};
      Bram_WrEn_SO = '0;
      Bram_Wr_DO   = '0;
      Bram_Clk_CO  = Clk_CI;
      Bram_Rst_RO  = ~Rst_RBI;
      NumRead_DO   = r_num_read;
   end

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         r_target        <= '0;
         r_rd_idx        <= '0;
         r_num_read      <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
      end else begin
         if (w_accept_start) begin
            // Oversized counts are clamped so the index never leaves the array.
            r_target   <= ((NumEntries_DI == '0) || (NumEntries_DI > FULL_CNT)) ?
                          FULL_CNT : NumEntries_DI;
            r_rd_idx   <= '0;
            r_num_read <= '0;
         end else begin
            if (w_issue) r_rd_idx <= r_rd_idx + 1'b1;
            if (w_pop)   r_num_read <= r_num_read + 1'b1;
         end
         r_inflight      <= w_issue;
         r_inflight_last <= w_issue && w_issue_last;
      end
   end

   bram_log_rd_buf #(
      .DATA_BITW    (LOG_DATA_BITW),
      .STOP_ON_ZERO (STOP_ON_ZERO)
   ) u_rd_buf (
      .i_clk          (Clk_CI),
      .i_rst_n        (Rst_RBI),
      .i_flush        (Abort_SI),
      .i_push         (w_push),
      .i_push_ts      (Bram_Rd_DI[TIMESTAMP_BITW-1:0]),
      .i_push_data    (Bram_Rd_DI[TIMESTAMP_BITW +: LOG_DATA_BITW]),
      .i_push_last    (r_inflight_last),
      .i_resolve      (r_inflight),
      .i_resolve_zero (w_rsp_zero),
      .i_ready        (Ready_SI),
      .o_valid        (Valid_SO),
      .o_last         (Last_SO),
      .o_pop          (w_pop),
      .o_ts           (Timestamp_DO),
      .o_data         (LogData_DO),
      .o_occ          (w_occ)
   );

endmodule

// File: tb/tb_bram_log_reader.sv
// tb/tb_bram_log_reader.sv - directed vector bench for bram_log_reader
module tb_bram_log_reader;
   import bram_logger_pkg::*;

   localparam int LOG_DATA_BITW   = 32;
   localparam int NUM_LOG_ENTRIES = 16384;
   localparam int ENTRY_BITW      = 64;
   localparam int CNT_BITW        = 14;
   localparam int ADDR_BITW       = 17;

   logic                      clk = 1'b0;
   logic                      rst_n;
   logic                      start;
   logic                      abort;
   logic [CNT_BITW:0]         num_entries;
   logic                      busy;
   logic                      done;
   logic [CNT_BITW:0]         num_read;
   logic [TIMESTAMP_BITW-1:0] ts;
   logic [LOG_DATA_BITW-1:0]  ldata;
   logic                      valid;
   logic                      ready;
   logic                      last;
   logic                      bram_clk;
   logic                      bram_rst;
   logic [ADDR_BITW-1:0]      bram_addr;
   logic                      bram_en;
   logic [ENTRY_BITW/8-1:0]   bram_wren;
   logic [ENTRY_BITW-1:0]     bram_wr;
   logic [ENTRY_BITW-1:0]     rd_q = '0;
   logic [ENTRY_BITW-1:0]     mem [NUM_LOG_ENTRIES];

   int n_vec  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bram_en) rd_q <= mem[bram_addr[ADDR_BITW-1:3]];
   end

   bram_log_reader #(
      .LOG_DATA_BITW   (LOG_DATA_BITW),
      .NUM_LOG_ENTRIES (NUM_LOG_ENTRIES),
      .STOP_ON_ZERO    (1'b1)
   ) dut (
      .Clk_CI        (clk),
      .Rst_RBI       (rst_n),
      .Start_SI      (start),
      .Abort_SI      (abort),
      .NumEntries_DI (num_entries),
      .Busy_SO       (busy),
      .Done_SO       (done),
      .NumRead_DO    (num_read),
      .Timestamp_DO  (ts),
      .LogData_DO    (ldata),
      .Valid_SO      (valid),
      .Ready_SI      (ready),
      .Last_SO       (last),
      .Bram_Clk_CO   (bram_clk),
      .Bram_Rst_RO   (bram_rst),
      .Bram_Addr_DO  (bram_addr),
      .Bram_En_SO    (bram_en),
      .Bram_WrEn_SO  (bram_wren),
      .Bram_Wr_DO    (bram_wr),
      .Bram_Rd_DI    (rd_q)
   );

   typedef struct {
      int zero_idx;
      int n_entries;
      int ready_pct;
      int exp_beats;
      int exp_issues;
      bit consec;
      int exp_last_ts;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic fill_table(input int zero_idx);
      for (int i = 0; i < 64; i++) begin
         mem[i] = {32'(2 * (10 + i)), 32'(10 + i)};
      end
      if (zero_idx >= 0) mem[zero_idx] = '0;
   endtask

   task automatic run_pass(input string name, input int n_entries, input int ready_pct,
                           input int exp_beats, input int exp_issues, input bit consec,
                           input int budget, output int last_ts);
      int beats = 0, issues = 0, done_cnt = 0, done_cyc = -1, last_beat_cyc = -10;
      int seq_err = 0, data_err = 0, last_err = 0, gap_err = 0, stab_err = 0;
      logic prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
      logic [TIMESTAMP_BITW-1:0] prev_ts = '0;
      logic [LOG_DATA_BITW-1:0]  prev_d  = '0;
      last_ts = -1;
      @(negedge clk);
      num_entries = (CNT_BITW + 1)'(n_entries);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc < budget && done_cnt == 0; cyc++) begin
         if (cyc > 0) @(negedge clk);
         ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < ready_pct);
         #1;
         if (cyc == 0) check({name, " busy_after_start"}, busy, 1);
         if (bram_en) begin
            if (bram_addr != ADDR_BITW'(issues << 3)) seq_err++;
            issues++;
         end
         if (prev_v && !prev_r &&
             (!valid || ts != prev_ts || ldata != prev_d || last != prev_l)) stab_err++;
         if (valid && ready) begin
            if (beats >= NUM_LOG_ENTRIES || {ldata, ts} != mem[beats]) data_err++;
            if (last != (beats == exp_beats - 1)) last_err++;
            if (beats > 0 && cyc != last_beat_cyc + 1) gap_err++;
            last_beat_cyc = cyc;
            last_ts = int'(ts);
            beats++;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         prev_v = valid; prev_r = ready; prev_l = last; prev_ts = ts; prev_d = ldata;
      end
      check({name, " done_pulses"}, done_cnt, 1);
      check({name, " beats"}, beats, exp_beats);
      check({name, " data_errors"}, data_err, 0);
      check({name, " last_errors"}, last_err, 0);
      check({name, " stability_errors"}, stab_err, 0);
      check({name, " addr_seq_errors"}, seq_err, 0);
      check({name, " reads_issued"}, issues, exp_issues);
      if (consec) check({name, " beat_gaps"}, gap_err, 0);
      if (exp_beats > 0) check({name, " done_delay"}, done_cyc - last_beat_cyc, 1);
      @(negedge clk);
      #1;
      check({name, " num_read"}, num_read, exp_beats);
      check({name, " busy_after_done"}, busy, 0);
      check({name, " done_one_cycle"}, done, 0);
      check({name, " valid_after_done"}, valid, 0);
      check({name, " en_after_done"}, bram_en, 0);
   endtask

   task automatic start_and_hold_two(output int beats, output int done_cnt);
      beats = 0;
      done_cnt = 0;
      @(negedge clk);
      num_entries = '0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         ready = (beats < 2);
         #1;
         if (valid && ready) beats++;
         if (done) done_cnt++;
         @(negedge clk);
      end
   endtask

   initial begin
      int lts, beats, done_cnt;
      vecs[0] = '{5,  0,  100, 5,  6,  1'b1, 14};
      vecs[1] = '{5,  3,  100, 3,  3,  1'b1, 12};
      vecs[2] = '{0,  0,  100, 0,  1,  1'b1, -1};
      vecs[3] = '{5,  1,  100, 1,  1,  1'b1, 10};
      vecs[4] = '{5,  5,  100, 5,  5,  1'b1, 14};
      vecs[5] = '{5,  6,  100, 5,  6,  1'b1, 14};
      vecs[6] = '{3,  0,  50,  3,  4,  1'b0, 12};
      vecs[7] = '{40, 20, 30,  20, 20, 1'b0, 29};

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0; num_entries = '0;
      for (int i = 0; i < NUM_LOG_ENTRIES; i++) mem[i] = '0;
      repeat (3) @(negedge clk);
      #1;
      check("reset valid", valid, 0);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset num_read", num_read, 0);
      check("reset timestamp", ts, 0);
      check("reset last", last, 0);
      check("reset bram_en", bram_en, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 8; v++) begin
         fill_table(vecs[v].zero_idx);
         run_pass($sformatf("vec%0d", v), vecs[v].n_entries, vecs[v].ready_pct,
                  vecs[v].exp_beats, vecs[v].exp_issues, vecs[v].consec, 300, lts);
         if (vecs[v].exp_beats > 0) check($sformatf("vec%0d last_ts", v), lts, vecs[v].exp_last_ts);
      end

      // Abort while a beat is held by backpressure, then a fresh pass restarts at entry 0.
      fill_table(5);
      start_and_hold_two(beats, done_cnt);
      ready = 1'b0;
      #1;
      check("abort held_valid", valid, 1);
      check("abort held_ts", ts, 12);
      abort = 1'b1;
      #1;
      if (done) done_cnt++;
      @(negedge clk);
      abort = 1'b0;
      #1;
      check("abort valid_dropped", valid, 0);
      check("abort busy_low", busy, 0);
      check("abort num_read", num_read, 2);
      check("abort beats", beats, 2);
      check("abort no_done", done_cnt, 0);
      run_pass("after_abort", 0, 100, 5, 6, 1'b1, 300, lts);
      check("after_abort last_ts", lts, 14);

      @(negedge clk);
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      #1;
      check("start_abort busy", busy, 0);
      check("start_abort en", bram_en, 0);

      // Asynchronous reset between clock edges mid-pass.
      start_and_hold_two(beats, done_cnt);
      ready = 1'b0;
      #2;
      check("rst_mid pre_valid", valid, 1);
      check("rst_mid pre_num_read", num_read, 2);
      rst_n = 1'b0;
      #1;
      check("rst_mid valid", valid, 0);
      check("rst_mid busy", busy, 0);
      check("rst_mid num_read", num_read, 0);
      check("rst_mid timestamp", ts, 0);
      check("rst_mid logdata", ldata, 0);
      check("rst_mid last", last, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_pass("after_reset", 0, 100, 5, 6, 1'b1, 300, lts);
      check("after_reset last_ts", lts, 14);

      for (int i = 0; i < NUM_LOG_ENTRIES; i++) begin
         mem[i] = {32'(i * 3 + 1), 32'(i + 1)};
      end
      run_pass("full_array", 0, 50, NUM_LOG_ENTRIES, NUM_LOG_ENTRIES, 1'b0, 40000, lts);
      check("full_array last_ts", lts, NUM_LOG_ENTRIES);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
